wrr_arbiter: RTL and testbench
==============================

# wrr_arbiter

Weighted round-robin arbiter that shares one downstream resource among N requesters. Each grant is held for up to a per-requester number of resource transactions, counted by `done` pulses, and then rotates. It sits between the requester ports and the shared resource, in place of the plain round-robin arbiter, wherever bursts must be bounded per requester.

## Interface
- `N`, 4: number of requesters, at least 2.
- `WW`, 4: weight width in bits.
- `clk`  in  1: clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `req`  in  N: request vector; bit i is requester i, level-sensitive.
- `weight`  in  N*WW: weight of requester i in bits `[i*WW +: WW]`; 0 is treated as 1.
- `done`  in  1: the resource completed one transaction for the current holder, one pulse per transaction.
- `lock`  in  1: present only with `ARB_LOCK_EN`; holder keeps the grant.
- `grant`  out  N: one-hot grant, registered; all zero when idle.
- `grant_id`  out  $clog2(N): index of the holder; valid while `grant` is nonzero.
- `credit`  out  WW: transactions remaining for the holder.

## Operation
- States: IDLE (no holder), BUSY (one holder h).
- Search order: start at `ptr`, ascend modulo N; the first asserted `req` bit wins.
- IDLE, some `req` bit asserted: winner w; `grant` <= onehot(w), `grant_id` <= w, `credit` <= max(weight[w],1); go BUSY.
- IDLE, no request: stay IDLE.
- BUSY, `req[h]`=1 and `done`=1 and `credit`>1: `credit` decrements; grant held.
- BUSY release condition: `req[h]`=0 (withdraw), or `done`=1 with `credit`=1.
- Simultaneous withdraw and `done`: a single release.
- On release: `ptr` <= (h+1) mod N.
  - Search from (h+1) mod N over the current `req` with `req[h]` masked. Masking applies only when h withdrew; on credit exhaustion h stays a candidate and can win last.
  - Winner found: re-grant on the same edge, back-to-back, no idle cycle, fresh `credit`.
  - No winner: `grant` <= 0, go IDLE.
- `done` in IDLE: ignored.
- `weight` is sampled only at grant time; later changes take effect on the next grant.
- `ptr` changes only on release; it wraps from N-1 to 0.
- `credit` never underflows: it is loaded with at least 1 and leaves BUSY at 1.
- `credit` reads 0 when IDLE.

## Timing
- Reset, synchronous while `rst_n`=0 at the edge: `grant`=0, `grant_id`=0, `credit`=0, `ptr`=0, state IDLE. Reset mid-burst drops the grant at that edge.
- Request-to-grant latency: 1 cycle. `req` sampled at edge k gives `grant` valid after edge k.
- Release-to-next-grant latency: 0 idle cycles. The new holder's `grant` is visible after the releasing edge.
- `done` is counted at the edge where it is sampled high.
- Up to `weight` transactions per tenure. The final `done` and the handover happen on the same edge.

## Configuration
- `ARB_LOCK_EN` defined:
  - The `lock` port exists.
  - While `lock`=1 in BUSY, credit exhaustion does not release. `credit` saturates at 1 and `done` is still accepted.
  - Withdraw (`req[h]`=0) still releases regardless of `lock`.
  - When `lock` falls with `credit`=1, the next `done` releases.
- `ARB_LOCK_EN` undefined:
  - The `lock` port is absent.
  - Behaviour is exactly as in Operation; no lock logic is synthesized.

## Test plan
- Reset and first grant: reset held 2 cycles, then `req`=0001 → all outputs 0 during reset; 1 cycle after `req` rises, `grant`=0001, `grant_id`=0, `credit`=weight0.
- Weighted rotation: weights {1,2,3,1}, `req`=1111, `done` every cycle → grant sequence 0001, 0010×2, 0100×3, 1000, 0001…, with no idle cycles.
- Withdraw mid-burst: holder 2 with weight 3 drops `req` after 1 `done`, `req`=1011 → next cycle `grant`=1000, `credit`=weight3.
- Zero weight and wrap: weight3=0, `req`=1000 then 1001 → requester 3 gets 1 transaction, then `grant`=0001 via the wrap to 0.
- Lone requester re-grant: `req`=0100, weight 2, 4 `done` pulses → `grant` stays 0100 throughout; `credit` reloads 2→1→2→1.
- Lock and reset: with `ARB_LOCK_EN`, `lock`=1, `req`=1111, weight0=1, 3 `done` → `grant` stays 0001. Reset asserted mid-burst → `grant`=0 on that edge, `ptr` returns to 0.

Source files
------------

// File: rtl/wrr_arbiter_if.sv
// Bundle between the requesters and the weighted round-robin arbiter.
// Macro ARB_LOCK_EN adds the lock signal to the bundle.
// master: requester/resource side; slave: the arbiter.
interface wrr_arbiter_if #(
    parameter int N  = 4,
    parameter int WW = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic            done;
`ifdef ARB_LOCK_EN
    logic            lock;
`endif
    logic [N-1:0]    grant;
    logic [IW-1:0]   grant_id;
    logic [WW-1:0]   credit;

`ifdef ARB_LOCK_EN
    modport master (output req, weight, done, lock, input grant, grant_id, credit);
    modport slave  (input req, weight, done, lock, output grant, grant_id, credit);
`else
    modport master (output req, weight, done, input grant, grant_id, credit);
    modport slave  (input req, weight, done, output grant, grant_id, credit);
`endif
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one holder at a time, each tenure bounded by
// the holder's weight counted in done pulses, then rotates.
// Optional feature macro: ARB_LOCK_EN (lock input keeps the grant past
// credit exhaustion; withdraw still releases).
module wrr_arbiter #(
    parameter int N  = 4,
    parameter int WW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    wrr_arbiter_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state_reg, state_next;
    logic [N-1:0]   grant_reg, grant_next;
    logic [IW-1:0]  grant_id_reg, grant_id_next;
    logic [IW-1:0]  ptr_reg, ptr_next;
    logic [WW-1:0]  credit_reg, credit_next;

    logic [WW-1:0]  weight_eff [N];
    logic [IW-1:0]  succ_id;
    logic [IW-1:0]  search_start;
    logic           found;
    logic [IW-1:0]  win;
    logic           lock_hold;
    logic           release_now;

    // Effective weight per requester: a zero weight grants one transaction.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_weight
            assign weight_eff[gi] = (bus.weight[gi*WW +: WW] == '0) ?
                                    WW'(1) : bus.weight[gi*WW +: WW];
        end
    endgenerate

`ifdef ARB_LOCK_EN
    assign lock_hold = bus.lock;
`else
    assign lock_hold = 1'b0;
`endif

    // Successor of the current holder, wrapping N-1 -> 0.
    assign succ_id = (grant_id_reg == IW'(N - 1)) ? '0 : grant_id_reg + IW'(1);

    // A withdrawing holder already has req low, so searching the raw req
    // vector both masks it on withdraw and keeps it a candidate (last) on
    // credit exhaustion.
    assign search_start = (state_reg == BUSY) ? succ_id : ptr_reg;

    // Release on withdraw, or on the final done unless lock holds the grant.
    assign release_now = (state_reg == BUSY) &&
                         (!bus.req[grant_id_reg] ||
                          (bus.done && credit_reg == WW'(1) && !lock_hold));

    // Rotating priority search: lowest offset from search_start wins.
    always_comb begin
        int          idx;
        logic [IW-1:0] idx_b;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_b = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(search_start) + i;
            if (idx >= N) idx = idx - N;
            idx_b = IW'(idx);
            if (bus.req[idx_b]) begin
                found = 1'b1;
                win   = idx_b;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        grant_id_next = grant_id_reg;
        ptr_next      = ptr_reg;
        credit_next   = credit_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    grant_next    = {{(N-1){1'b0}}, 1'b1} << win;
                    grant_id_next = win;
                    credit_next   = weight_eff[win];
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_next = succ_id;
                    if (found) begin
                        grant_next    = {{(N-1){1'b0}}, 1'b1} << win;
                        grant_id_next = win;
                        credit_next   = weight_eff[win];
                    end else begin
                        grant_next  = '0;
                        credit_next = '0;
                        state_next  = IDLE;
                    end
                end else if (bus.done && credit_reg > WW'(1)) begin
                    credit_next = credit_reg - WW'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                grant_next  = '0;
                credit_next = '0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            grant_id_reg <= '0;
            ptr_reg      <= '0;
            credit_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            grant_id_reg <= grant_id_next;
            ptr_reg      <= ptr_next;
            credit_reg   <= credit_next;
        end
    end

    assign bus.grant    = grant_reg;
    assign bus.grant_id = grant_id_reg;
    assign bus.credit   = credit_reg;
endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed testbench for wrr_arbiter (N=4, WW=4); lock checks under ARB_LOCK_EN.
module tb_wrr_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    wrr_arbiter_if #(.N(4), .WW(4)) bus ();

    wrr_arbiter #(.N(4), .WW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] ROT_G [8] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100,
                                         4'b0100, 4'b1000, 4'b0001, 4'b0010};
    localparam logic [3:0] ROT_C [8] = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd1, 4'd1, 4'd2};
    localparam logic [3:0] LONE_C [4] = '{4'd1, 4'd2, 4'd1, 4'd2};

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.req    = 4'b0000;
        bus.done   = 1'b0;
        bus.weight = 16'h1321;   // w3=1 w2=3 w1=2 w0=1
`ifdef ARB_LOCK_EN
        bus.lock   = 1'b0;
`endif
        // Reset held two cycles
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_grant", 32'(bus.grant), 32'h0);
            check("rst_id", 32'(bus.grant_id), 32'h0);
            check("rst_credit", 32'(bus.credit), 32'h0);
        end
        rst_n   = 1'b1;
        bus.req = 4'b0001;
        tick();
        check("first_grant", 32'(bus.grant), 32'h1);
        check("first_id", 32'(bus.grant_id), 32'h0);
        check("first_credit", 32'(bus.credit), 32'h1);

        // Weighted rotation, done every cycle
        bus.req  = 4'b1111;
        bus.done = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rot_grant%0d", i), 32'(bus.grant), 32'(ROT_G[i]));
            check($sformatf("rot_credit%0d", i), 32'(bus.credit), 32'(ROT_C[i]));
        end

        // Withdraw mid-burst by holder 2
        tick();
        tick();
        check("wd_pre_grant", 32'(bus.grant), 32'h4);
        check("wd_pre_credit", 32'(bus.credit), 32'h3);
        tick();
        check("wd_one_done", 32'(bus.credit), 32'h2);
        bus.req  = 4'b1011;
        bus.done = 1'b0;
        tick();
        check("wd_grant", 32'(bus.grant), 32'h8);
        check("wd_id", 32'(bus.grant_id), 32'h3);
        check("wd_credit", 32'(bus.credit), 32'h1);

        // Zero weight and wrap
        bus.weight = 16'h0321;
        bus.req    = 4'b0000;
        tick();
        check("idle_grant", 32'(bus.grant), 32'h0);
        check("idle_credit", 32'(bus.credit), 32'h0);
        bus.done = 1'b1;
        tick();
        check("idle_done_ignored", 32'(bus.grant), 32'h0);
        bus.done = 1'b0;
        bus.req  = 4'b1000;
        tick();
        check("zw_grant", 32'(bus.grant), 32'h8);
        check("zw_credit", 32'(bus.credit), 32'h1);
        bus.req  = 4'b1001;
        bus.done = 1'b1;
        tick();
        check("wrap_grant", 32'(bus.grant), 32'h1);
        check("wrap_id", 32'(bus.grant_id), 32'h0);

        // Lone requester re-grant (holder 0 withdraws with done: one release)
        bus.weight = 16'h0221;
        bus.req    = 4'b0100;
        tick();
        check("lone_grant", 32'(bus.grant), 32'h4);
        check("lone_credit", 32'(bus.credit), 32'h2);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("lone_grant%0d", i), 32'(bus.grant), 32'h4);
            check($sformatf("lone_credit%0d", i), 32'(bus.credit), 32'(LONE_C[i]));
        end

        // Reset mid-burst drops grant and returns ptr to 0
        rst_n    = 1'b0;
        bus.done = 1'b0;
        tick();
        check("midrst_grant", 32'(bus.grant), 32'h0);
        check("midrst_credit", 32'(bus.credit), 32'h0);
        rst_n   = 1'b1;
        bus.req = 4'b1111;
        tick();
        check("ptr_reset_grant", 32'(bus.grant), 32'h1);
        check("ptr_reset_credit", 32'(bus.credit), 32'h1);

`ifdef ARB_LOCK_EN
        // Lock holds requester 0 past credit exhaustion
        bus.lock = 1'b1;
        bus.done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("lock_grant%0d", i), 32'(bus.grant), 32'h1);
            check($sformatf("lock_credit%0d", i), 32'(bus.credit), 32'h1);
        end
        bus.lock = 1'b0;
        tick();
        check("unlock_grant", 32'(bus.grant), 32'h2);
        check("unlock_credit", 32'(bus.credit), 32'h2);
        bus.done = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
